// File: rtl/timer_pkg.sv
// Shared encodings for the timer_irq peripheral: FSM states, register
// addresses, mode values and CTRL bit positions.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } timer_state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_MODE_HI = 2;
  localparam int unsigned CTRL_IM      = 3;
  localparam int unsigned CTRL_PEND    = 4;

  localparam int unsigned DATA_W = 32;

endpackage

// File: rtl/timer_irq.sv
// 32-bit down-counting timer with one-shot / periodic modes, driving one
// CP0 HWInt line through a registered IRQ.
module timer_irq
  import timer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        Addr,
  input  logic              WE,
  input  logic [DATA_W-1:0] DIn,
  output logic [DATA_W-1:0] DOut,
  output logic              IRQ
);

  timer_state_e      r_state;
  timer_state_e      w_state_nxt;
  logic              r_enable;
  logic [1:0]        r_mode;
  logic              r_im;
  logic              r_pend;
  logic [DATA_W-1:0] r_preset;
  logic [DATA_W-1:0] r_count;

  logic              w_enable_nxt;
  logic [1:0]        w_mode_nxt;
  logic              w_im_nxt;
  logic              w_pend_nxt;
  logic [DATA_W-1:0] w_count_nxt;
  logic              w_irq_nxt;

  logic w_ctrl_wr;
  logic w_preset_wr;
  logic w_en_eff;
  logic w_periodic;
  logic w_unused_din;

  assign w_ctrl_wr    = WE && (Addr == ADDR_CTRL);
  assign w_preset_wr  = WE && (Addr == ADDR_PRESET);
  // A same-cycle CTRL write overrides Enable so an abort takes effect immediately.
  assign w_en_eff     = w_ctrl_wr ? DIn[CTRL_EN] : r_enable;
  assign w_periodic   = (r_mode == MODE_PERIODIC);
  assign w_unused_din = ^DIn[DATA_W-1:CTRL_PEND];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (r_enable) w_state_nxt = ST_LOAD;
      ST_LOAD: w_state_nxt = w_en_eff ? ST_CNT : ST_IDLE;
      ST_CNT: begin
        if (!w_en_eff) begin
          w_state_nxt = ST_IDLE;
        end else if (r_count <= DATA_W'(1)) begin
          w_state_nxt = ST_INT;
        end
      end
      ST_INT:  w_state_nxt = w_periodic ? ST_LOAD : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    w_enable_nxt = r_enable;
    w_mode_nxt   = r_mode;
    w_im_nxt     = r_im;
    w_pend_nxt   = r_pend;
    w_count_nxt  = r_count;

    if (w_ctrl_wr) begin
      w_enable_nxt = DIn[CTRL_EN];
      w_mode_nxt   = DIn[CTRL_MODE_HI:CTRL_MODE_LO];
      w_im_nxt     = DIn[CTRL_IM];
    end else if ((r_state == ST_INT) && !w_periodic) begin
      w_enable_nxt = 1'b0;
    end

    // Setting Pend on INT entry beats a coincident clearing write.
    if ((r_state == ST_CNT) && (w_state_nxt == ST_INT)) begin
      w_pend_nxt = 1'b1;
    end else if (w_ctrl_wr) begin
      w_pend_nxt = 1'b0;
    end else if ((r_state == ST_INT) && w_periodic) begin
      w_pend_nxt = 1'b0;
    end

    if ((r_state == ST_LOAD) && w_en_eff) begin
      w_count_nxt = r_preset;
    end else if ((r_state == ST_CNT) && w_en_eff) begin
      w_count_nxt = (r_count > DATA_W'(1)) ? (r_count - DATA_W'(1)) : '0;
    end

    w_irq_nxt = w_pend_nxt & w_im_nxt;
  end

  // Register block
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_enable <= 1'b0;
      r_mode   <= MODE_ONESHOT;
      r_im     <= 1'b0;
      r_pend   <= 1'b0;
      r_preset <= '0;
      r_count  <= '0;
      IRQ      <= 1'b0;
    end else begin
      r_enable <= w_enable_nxt;
      r_mode   <= w_mode_nxt;
      r_im     <= w_im_nxt;
      r_pend   <= w_pend_nxt;
      r_count  <= w_count_nxt;
      IRQ      <= w_irq_nxt;
      if (w_preset_wr) r_preset <= DIn;
    end
  end

  // Zero-latency read mux
  always_comb begin
    DOut = '0;
    case (Addr)
      ADDR_CTRL:   DOut = {27'b0, r_pend, r_im, r_mode, r_enable};
      ADDR_PRESET: DOut = r_preset;
      ADDR_COUNT:  DOut = r_count;
      default:     DOut = '0;
    endcase
  end

endmodule
